mac_ofifo: RTL
==============

// Module: mac_ofifo
// PURPOSE
// Output collector directly downstream of the mac_array (bottom edge of the mac_tile columns).
// Each column's out_s psum is captured into a dedicated per-column FIFO when that column flags it
// valid. Column psums emerge skewed in time, so a full output row is popped only when every column
// holds data. Popped rows go to the psum SRAM write path in one wide registered word.
// PARAMETERS
// col      8   number of array columns (one FIFO per column)
// psum_bw  16  psum width per column, matches mac_tile psum_bw
// depth    64  entries per column FIFO; power of two, >= 2
// PORTS
// clk       in   1              rising-edge clock
// reset     in   1              asynchronous, active-low reset
// wr        in   col            per-column write strobe (bit i = column i psum valid)
// in        in   col*psum_bw    column psums; column i at [psum_bw*(i+1)-1 : psum_bw*i]
// rd        in   1              pop one full row
// out       out  col*psum_bw    registered popped row, same column packing as in
// o_valid   out  1              1-cycle pulse: out holds a newly popped row
// o_ready   out  1              every column FIFO non-empty (a row may be popped)
// o_full    out  1              any column FIFO full
// o_ovf     out  1              sticky: a write hit a full column
// o_udf     out  1              sticky: rd asserted while o_ready low
// BEHAVIOUR
// - Reset (reset=0, async): all write/read pointers 0, out=0, o_valid=0, o_ovf=0, o_udf=0.
//   Hence o_ready=0, o_full=0. Storage contents are don't-care. A reset mid-operation discards all data.
// - Pointers: per-column wr_ptr, one shared rd_ptr, each log2(depth)+1 bits (extra wrap bit).
//   Column i is empty when wr_ptr[i]==rd_ptr. It is full when the low bits are equal and the wrap bits differ.
// - Write: on a clk edge with wr[i]=1, column i stores its in slice at wr_ptr[i] and wr_ptr[i]++.
//   Columns are independent; any subset may write in the same cycle.
// - Full column: a write to column i is accepted only if column i is not full at the start of the cycle.
//   A concurrent rd does NOT free space for the same-cycle write. A rejected write is dropped,
//   wr_ptr[i] holds, and o_ovf sets next edge (cleared only by reset).
// - o_ready = AND over columns of (not empty). o_full = OR over columns of full. Both are combinational from pointers.
// - Read: on a clk edge with rd=1 and o_ready=1:
//   - out <= entries at rd_ptr from every column;
//   - rd_ptr++;
//   - o_valid=1 for exactly the next cycle.
//   Read latency is 1 cycle (rd edge -> out/o_valid valid after that edge).
// - Read with o_ready=0: ignored. Pointers, out and o_valid=0 are unchanged, and o_udf sets (sticky).
// - out holds its last popped value until the next successful pop. o_valid is 0 whenever no pop occurred on the previous edge.
// - Simultaneous write and read on a non-full column: both take effect.
//   A write into an empty column in cycle t does not make that column readable until t+1 (o_ready uses registered pointers).
// - Wrap-around: pointers wrap modulo 2*depth. Storage is indexed by the low log2(depth) bits.
//   Data order is strictly FIFO per column across wrap.
// - Row integrity: the shared rd_ptr means row k of out is always the k-th psum written to each column,
//   regardless of per-column skew.
// TESTING
// T1 reset: drive writes, then assert reset=0 asynchronously between edges.
//   -> o_ready=0, o_valid=0, o_ovf=0, out=0 immediately, without waiting for a clk edge.
// T2 skew: col=8, write column i with psum 16'h0100+i at cycle t0+i.
//   -> o_ready stays 0 until the cycle after column 7 writes.
//   -> a rd then gives o_valid=1 for 1 cycle, out = {16'h0107,...,16'h0100}, and o_ready=0 after.
// T3 full/overflow: write 64 entries to every column, then 1 more to column 3.
//   -> o_full=1 after the 64th write, o_ovf=1 after the extra write.
//   -> column 3 drain order is unchanged (64 values, extra value absent).
// T4 underflow: rd=1 with all FIFOs empty.
//   -> o_valid stays 0, out unchanged, o_udf=1, and a subsequent valid fill/pop works normally.
// T5 wrap: stream 200 rows with a write and a read in the same cycle, keeping occupancy between 1 and 63.
//   -> all 200 rows emerge in order with exact values, and o_ovf=o_udf=0.
// T6 full+read same cycle: column 0 full with rd=1 and wr[0]=1.
//   -> the pop succeeds, the write is dropped, o_ovf=1, and column 0 occupancy becomes 63.

Source files
------------

// File: rtl/mac_ofifo.sv
// Purpose : per-column psum collector below the mac_array; pops a full aligned row once every column holds data.
// Latency : 1 cycle from an accepted rd edge to out/o_valid; a write becomes visible to o_ready one cycle later.
// Backpressure: writes to a full column are dropped (o_ovf sticky); rd while o_ready low is ignored (o_udf sticky).
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   wr       per-column write strobe, bit i = column i psum valid
//   in       column psums, column i at [psum_bw*(i+1)-1 : psum_bw*i]
//   rd       pop one full row
//   out      registered popped row, same packing as in
//   o_valid  one-cycle pulse when out holds a newly popped row
//   o_ready  every column FIFO non-empty
//   o_full   any column FIFO full
//   o_ovf    sticky write-to-full flag
//   o_udf    sticky read-while-not-ready flag
module mac_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col-1:0]           wr,
    input  logic [col*psum_bw-1:0]   in,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_ready,
    output logic                     o_full,
    output logic                     o_ovf,
    output logic                     o_udf
);

    localparam int AW = $clog2(depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]          wr_ptr [col];
    logic [AW:0]          rd_ptr;
    logic [psum_bw-1:0]   mem    [col][depth];

    logic [col-1:0]       col_empty;
    logic [col-1:0]       col_full;
    logic [col-1:0]       wr_acc;
    logic                 pop;

    always_comb begin
        col_empty = '0;
        col_full  = '0;
        for (int i = 0; i < col; i++) begin
            col_empty[i] = (wr_ptr[i] == rd_ptr);
            col_full[i]  = (wr_ptr[i][AW-1:0] == rd_ptr[AW-1:0]) &&
                           (wr_ptr[i][AW]     != rd_ptr[AW]);
        end
    end

    assign o_ready = ~|col_empty;
    assign o_full  = |col_full;
    assign pop     = rd & o_ready;
    // Fullness is judged on the registered pointers, so a same-cycle pop never frees room for a write.
    assign wr_acc  = wr & ~col_full;

    // Storage has no reset; its contents are only ever observed behind a valid pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_acc[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= in[i*psum_bw +: psum_bw];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < col; i++) begin
                wr_ptr[i] <= '0;
            end
            rd_ptr  <= '0;
            out     <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            o_udf   <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_acc[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
            end
            o_valid <= pop;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                for (int i = 0; i < col; i++) begin
                    out[i*psum_bw +: psum_bw] <= mem[i][rd_ptr[AW-1:0]];
                end
            end
            if (|(wr & col_full)) begin
                o_ovf <= 1'b1;
            end
            if (rd && !o_ready) begin
                o_udf <= 1'b1;
            end
        end
    end

endmodule
